// File: rtl/nocif_dram_read_req_split.sv
// Per-client DRAM read-request splitter with latency-FIFO credit gate.
// Breaks {size, addr} client requests into window-aligned bursts of at most
// 2**MAX_BEATS_LOG2 atoms. A burst is offered only when the latency FIFO has
// room for all of its returning beats.
// Optional feature macro: NVDLA_RD_SPLIT_PERF_EN adds perf_credit_stall[31:0].
module nocif_dram_read_req_split #(
  parameter int AW             = 64,
  parameter int ATOM_LOG2      = 5,
  parameter int MAX_BEATS_LOG2 = 2
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 client_rd_req_valid,
  output logic                 client_rd_req_ready,
  input  logic [AW+14:0]       client_rd_req_pd,
  input  logic                 client_rd_cdt_lat_fifo_pop,
  input  logic [7:0]           client_lat_fifo_depth,
  input  logic [3:0]           client_rd_axid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW-1:0]        out_addr,
  output logic [1:0]           out_len,
  output logic [3:0]           out_axid,
  output logic [6:0]           out_ctx
`ifdef NVDLA_RD_SPLIT_PERF_EN
  ,
  output logic [31:0]          perf_credit_stall
`endif
);

  localparam int BW = MAX_BEATS_LOG2 + 1;        // beats counter width (1..MB)
  localparam int MB = 1 << MAX_BEATS_LOG2;       // max atoms per burst

  typedef enum logic {S_IDLE, S_SPLIT} state_t;

  state_t               r_state, w_state_nxt;
  logic [AW-1:0]        r_addr;
  logic [15:0]          r_rem;
  logic                 r_first;
  logic [2:0]           r_seq;
  logic [8:0]           r_outst;

  logic [AW-1:0]        w_req_addr;
  logic [15:0]          w_req_rem;
  logic [MAX_BEATS_LOG2-1:0] w_off;
  logic [BW-1:0]        w_win;
  logic [BW-1:0]        w_beats;
  logic [BW-1:0]        w_len;
  logic                 w_last;
  logic [9:0]           w_avail;
  logic                 w_credit_ok;
  logic                 w_split;
  logic                 w_fire;
  logic                 w_accept;
  logic                 w_pop_eff;
  logic [8:0]           w_inc;

  // Request decode: drop the sub-atom address bits, convert size to atom count.
  assign w_req_addr = client_rd_req_pd[AW-1:0] & ~AW'((1 << ATOM_LOG2) - 1);
  assign w_req_rem  = {1'b0, client_rd_req_pd[AW+14:AW]} + 16'd1;

  // Burst sizing: never cross the burst window, never exceed what is left.
  assign w_split = (r_state == S_SPLIT);
  assign w_off   = r_addr[ATOM_LOG2+MAX_BEATS_LOG2-1:ATOM_LOG2];
  assign w_win   = BW'(MB) - {1'b0, w_off};
  assign w_beats = (r_rem < {{(16-BW){1'b0}}, w_win}) ? r_rem[BW-1:0] : w_win;
  assign w_len   = w_beats - BW'(1);
  assign w_last  = ({{(16-BW){1'b0}}, w_beats} == r_rem);

  // Credit gate: outstanding never exceeds depth, so the difference stays positive.
  assign w_avail     = {2'b00, client_lat_fifo_depth} - {1'b0, r_outst};
  assign w_credit_ok = (w_avail >= {{(10-BW){1'b0}}, w_beats});

  assign out_valid = w_split && w_credit_ok;
  assign w_fire    = out_valid && out_ready;
  assign w_accept  = client_rd_req_valid && client_rd_req_ready;

  // Payload is zero outside SPLIT so idle outputs match the reset values.
  assign out_addr = w_split ? r_addr : '0;
  assign out_len  = w_split ? w_len[MAX_BEATS_LOG2-1:0] : '0;
  assign out_ctx  = w_split ? {w_last, r_first, w_len[1:0], r_seq} : '0;
  assign out_axid = client_rd_axid;

  // Pops against an empty count are dropped; issue and pop may coincide.
  assign w_pop_eff = client_rd_cdt_lat_fifo_pop && (r_outst != 9'd0);
  assign w_inc     = w_fire ? {{(9-BW){1'b0}}, w_beats} : 9'd0;

  // State register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // Next state and client handshake; ready is held low while in reset.
  always_comb begin
    w_state_nxt         = r_state;
    client_rd_req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        client_rd_req_ready = nvdla_core_rstn;
        if (w_accept) w_state_nxt = S_SPLIT;
      end
      S_SPLIT: begin
        if (w_fire && w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request walker: capture on accept, advance address/remainder per burst.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_addr  <= '0;
      r_rem   <= '0;
      r_first <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= w_req_addr;
      r_rem   <= w_req_rem;
      r_first <= 1'b1;
    end else if (w_fire) begin
      r_addr  <= r_addr + (AW'(w_beats) << ATOM_LOG2);
      r_rem   <= r_rem - {{(16-BW){1'b0}}, w_beats};
      r_first <= 1'b0;
    end
  end

  // Burst sequence number runs freely across requests, wrapping naturally.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_seq <= '0;
    else if (w_fire)      r_seq <= r_seq + 3'd1;
  end

  // Outstanding beat count owed to the latency FIFO.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_outst <= '0;
    else                  r_outst <= r_outst + w_inc - {8'd0, w_pop_eff};
  end

`ifdef NVDLA_RD_SPLIT_PERF_EN
  logic [31:0] r_perf;
  // Count cycles a burst is ready to go but held back by credits; saturating.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)                                  r_perf <= '0;
    else if (w_split && !w_credit_ok && (r_perf != '1))    r_perf <= r_perf + 32'd1;
  end
  assign perf_credit_stall = r_perf;
`endif

`ifndef SYNTHESIS
  // A depth smaller than the burst can never open the gate: programming error.
  a_depth_too_small: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (w_split && (r_outst == 9'd0)) |-> out_valid)
    else $error("lat fifo depth %0d below burst size %0d", client_lat_fifo_depth, w_beats);

  // Offered burst must hold until taken.
  a_hold_stable: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_addr) && $stable(out_len) && $stable(out_ctx)))
    else $error("burst payload changed while stalled");
`endif

endmodule
